clock_gate_ctrl: RTL and testbench
==================================

// Module: clock_gate_ctrl
//
// PURPOSE
// Idle-driven enable sequencer for the Tritone per-domain clock_gate cells.
// Watches each domain's busy flag, drops that domain's clock enable after a
// programmable idle window, re-enables it on wake demand, and reports a ready
// flag once the restarted clock has settled. One instance sits in the core top,
// its cg_en[i] outputs driving the en input of clock_gate instance i.
//
// PARAMETERS
// N_DOMAINS    4    number of gated clock domains (1..16)
// IDLE_CYCLES  16   consecutive idle cycles before gating (>=1)
// WAKE_CYCLES  2    cycles from enable re-assertion to ready (>=1)
//
// PORTS
// clk           in   1          core clock (ungated; ctrl itself never gated)
// rst_n         in   1          asynchronous reset, active low
// busy          in   N_DOMAINS  domain i has work in flight / pending
// wake_req      in   N_DOMAINS  external wake request for domain i (level)
// gate_allow    in   N_DOMAINS  config: domain i may be gated
// force_on      in   1          global override: ungate every domain
// cg_en         out  N_DOMAINS  enable to clock_gate.en of domain i (registered)
// dom_ready     out  N_DOMAINS  domain i clocked and settled; may accept work
// dom_gated     out  N_DOMAINS  domain i currently in GATED
// all_gated     out  1          AND of dom_gated
//
// BEHAVIOUR
// - Per-domain FSM, independent instances: RUN, GATED, WAKE.
// - Reset (async, rst_n=0): every FSM -> RUN immediately; cg_en=all 1,
//   dom_ready=all 1, dom_gated=0, all_gated=0, idle/wake counters=0.
//   Reset asserted mid-GATED or mid-WAKE forces RUN the same instant.
// - idle condition(i) = !busy[i] & !wake_req[i] & gate_allow[i] & !force_on.
// - RUN: cg_en=1, dom_ready=1. idle_cnt increments each cycle idle(i) holds,
//   clears to 0 on any cycle it does not. When idle holds with
//   idle_cnt==IDLE_CYCLES-1, next state GATED. First idle cycle t -> cg_en
//   low from edge t+IDLE_CYCLES. idle_cnt saturates, never wraps.
// - Simultaneous: busy/wake rising in the threshold cycle -> stays RUN,
//   idle_cnt cleared (activity wins).
// - GATED: cg_en=0, dom_ready=0, dom_gated=1. Exit to WAKE on any of
//   busy[i], wake_req[i], force_on, !gate_allow[i]; cg_en returns to 1 the
//   next edge. idle_cnt held at 0.
// - WAKE: cg_en=1, dom_ready=0, dom_gated=0; wake_cnt counts from 0; after
//   WAKE_CYCLES cycles in WAKE -> RUN (dom_ready=1). Inputs ignored in WAKE
//   (no abort back to GATED); idle_cnt restarts at 0 on RUN entry.
// - Wake latency: trigger sampled at edge k -> cg_en=1 after k,
//   dom_ready=1 after edge k+WAKE_CYCLES.
// - All outputs are flop outputs (no combinational input->output path) so
//   cg_en is stable through the clock_gate latch's transparent phase.
// - force_on held: every domain reaches RUN within WAKE_CYCLES+1 cycles and
//   stays there.
// - Counter widths: $clog2(IDLE_CYCLES+1), $clog2(WAKE_CYCLES+1).
// - No test_en handling here: scan bypass is inside clock_gate.
//
// TESTING
// 1 Reset: rst_n=0 with busy=0 -> cg_en=4'b1111, dom_ready=4'b1111,
//   dom_gated=0; release rst_n, hold busy=0, allow=1111 -> cg_en=0000 after
//   exactly 16 edges, all_gated=1.
// 2 Idle break: busy[0] low 15 cycles, high 1, low 16 -> cg_en[0] stays 1
//   until the 16th cycle of the second window; other domains unaffected.
// 3 Wake: domain 2 GATED, pulse wake_req[2] 1 cycle -> cg_en[2]=1 next edge,
//   dom_ready[2]=1 two edges later, then regates 16 idle cycles on.
// 4 Threshold collision: busy[1] rises in cycle 16 of idle -> no gating,
//   cg_en[1] never drops, idle_cnt restarts.
// 5 Overrides: gate_allow=0101 -> domains 1,3 never gate; force_on=1 while
//   all GATED -> all cg_en=1 next edge, all dom_ready=1 after 2 more; clear
//   gate_allow[0] while GATED -> domain 0 wakes.
// 6 Async reset mid-WAKE: drop rst_n between edges -> cg_en/dom_ready go to
//   1 without a clock edge; FSM in RUN with counters 0 after release.

Source files
------------

// File: rtl/clock_gate_ctrl.sv
// Per-domain clock-enable sequencer: gates a domain after a run of idle cycles,
// reopens it on demand and flags ready once the restarted clock has settled.
module clock_gate_ctrl #(
    parameter int N_DOMAINS   = 4,
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_DOMAINS-1:0] busy,
    input  logic [N_DOMAINS-1:0] wake_req,
    input  logic [N_DOMAINS-1:0] gate_allow,
    input  logic                 force_on,
    output logic [N_DOMAINS-1:0] cg_en,
    output logic [N_DOMAINS-1:0] dom_ready,
    output logic [N_DOMAINS-1:0] dom_gated,
    output logic                 all_gated
);

    localparam int IDLE_W = (IDLE_CYCLES > 0) ? $clog2(IDLE_CYCLES + 1) : 1;
    localparam int WAKE_W = (WAKE_CYCLES > 0) ? $clog2(WAKE_CYCLES + 1) : 1;
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_CYCLES - 1);
    localparam logic [WAKE_W-1:0] WAKE_MAX = WAKE_W'(WAKE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_GATED = 2'd1,
        ST_WAKE  = 2'd2
    } state_t;

    logic [N_DOMAINS-1:0] w_gated_nxt;
    logic                 r_all_gated;

    for (genvar g = 0; g < N_DOMAINS; g++) begin : g_dom
        state_t              r_state;
        state_t              w_state_nxt;
        logic [IDLE_W-1:0]   r_idle_cnt;
        logic [IDLE_W-1:0]   w_idle_nxt;
        logic [WAKE_W-1:0]   r_wake_cnt;
        logic [WAKE_W-1:0]   w_wake_nxt;
        logic                r_cg_en;
        logic                r_ready;
        logic                r_gated;
        logic                w_idle;

        assign w_idle = !busy[g] && !wake_req[g] && gate_allow[g] && !force_on;

        always_comb begin
            w_state_nxt = r_state;
            w_idle_nxt  = '0;
            w_wake_nxt  = '0;
            case (r_state)
                ST_RUN: begin
                    if (w_idle) begin
                        if (r_idle_cnt == IDLE_MAX) begin
                            w_state_nxt = ST_GATED;
                        end else if (r_idle_cnt < IDLE_MAX) begin
                            w_idle_nxt = r_idle_cnt + 1'b1;
                        end else begin
                            w_idle_nxt = r_idle_cnt;
                        end
                    end
                end
                ST_GATED: begin
                    // Any reason not to be idle is a reason to reopen the clock.
                    if (!w_idle) begin
                        w_state_nxt = ST_WAKE;
                    end
                end
                ST_WAKE: begin
                    if (r_wake_cnt == WAKE_MAX) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_wake_nxt = r_wake_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_RUN;
                end
            endcase
        end

        assign w_gated_nxt[g] = (w_state_nxt == ST_GATED);

        // Outputs are registered from the next state so cg_en never has a
        // combinational path from inputs into the clock_gate latch.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state    <= ST_RUN;
                r_idle_cnt <= '0;
                r_wake_cnt <= '0;
                r_cg_en    <= 1'b1;
                r_ready    <= 1'b1;
                r_gated    <= 1'b0;
            end else begin
                r_state    <= w_state_nxt;
                r_idle_cnt <= w_idle_nxt;
                r_wake_cnt <= w_wake_nxt;
                r_cg_en    <= (w_state_nxt != ST_GATED);
                r_ready    <= (w_state_nxt == ST_RUN);
                r_gated    <= (w_state_nxt == ST_GATED);
            end
        end

        assign cg_en[g]     = r_cg_en;
        assign dom_ready[g] = r_ready;
        assign dom_gated[g] = r_gated;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_all_gated <= 1'b0;
        end else begin
            r_all_gated <= &w_gated_nxt;
        end
    end

    assign all_gated = r_all_gated;

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Directed bench for clock_gate_ctrl: idle gating, idle break, wake latency,
// threshold collision, overrides and asynchronous reset mid-wake.
module tb_clock_gate_ctrl;

    logic       clk;
    logic       rst_n;
    logic [3:0] busy;
    logic [3:0] wake_req;
    logic [3:0] gate_allow;
    logic       force_on;
    logic [3:0] cg_en;
    logic [3:0] dom_ready;
    logic [3:0] dom_gated;
    logic       all_gated;

    int n_pass  = 0;
    int n_total = 0;

    clock_gate_ctrl #(
        .N_DOMAINS  (4),
        .IDLE_CYCLES(16),
        .WAKE_CYCLES(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .busy      (busy),
        .wake_req  (wake_req),
        .gate_allow(gate_allow),
        .force_on  (force_on),
        .cg_en     (cg_en),
        .dom_ready (dom_ready),
        .dom_gated (dom_gated),
        .all_gated (all_gated)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    // Advance n rising edges, then settle 1ns past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        busy       = 4'b0000;
        wake_req   = 4'b0000;
        gate_allow = 4'b1111;
        force_on   = 1'b0;

        // 1: reset state, then gating after exactly 16 idle edges
        step(2);
        chk("rst_cg_en", cg_en, 4'b1111);
        chk("rst_ready", dom_ready, 4'b1111);
        chk("rst_gated", dom_gated, 4'b0000);
        chk("rst_all_gated", {3'b000, all_gated}, 4'b0000);
        rst_n = 1'b1;
        step(15);
        chk("idle15_cg_en", cg_en, 4'b1111);
        step(1);
        chk("idle16_cg_en", cg_en, 4'b0000);
        chk("idle16_ready", dom_ready, 4'b0000);
        chk("idle16_gated", dom_gated, 4'b1111);
        chk("idle16_all_gated", {3'b000, all_gated}, 4'b0001);

        // 2: idle break on domain 0
        busy = 4'b0001;
        step(4);
        chk("d0_run_cg_en", cg_en, 4'b0001);
        chk("d0_run_ready", dom_ready, 4'b0001);
        chk("d0_run_gated", dom_gated, 4'b1110);
        chk("d0_run_all_gated", {3'b000, all_gated}, 4'b0000);
        busy = 4'b0000;
        step(15);
        chk("brk_low15", cg_en, 4'b0001);
        busy = 4'b0001;
        step(1);
        chk("brk_high1", cg_en, 4'b0001);
        busy = 4'b0000;
        step(15);
        chk("brk_second15", cg_en, 4'b0001);
        step(1);
        chk("brk_second16", cg_en, 4'b0000);

        // 3: wake pulse on domain 2
        wake_req = 4'b0100;
        step(1);
        chk("wake_cg_en", cg_en, 4'b0100);
        chk("wake_ready_k", dom_ready, 4'b0000);
        wake_req = 4'b0000;
        step(1);
        chk("wake_ready_k1", dom_ready, 4'b0000);
        step(1);
        chk("wake_ready_k2", dom_ready, 4'b0100);
        chk("wake_cg_en_k2", cg_en, 4'b0100);
        step(15);
        chk("wake_regate15", cg_en, 4'b0100);
        step(1);
        chk("wake_regate16", cg_en, 4'b0000);

        // 4: busy rises on the threshold cycle of domain 1
        busy = 4'b0010;
        step(4);
        chk("thr_run", dom_ready, 4'b0010);
        busy = 4'b0000;
        step(15);
        chk("thr_pre", cg_en, 4'b0010);
        busy = 4'b0010;
        step(1);
        chk("thr_collide", cg_en, 4'b0010);
        busy = 4'b0000;
        step(15);
        chk("thr_restart15", cg_en, 4'b0010);
        step(1);
        chk("thr_restart16", cg_en, 4'b0000);

        // 5: gate_allow and force_on overrides
        gate_allow = 4'b0101;
        step(1);
        chk("allow_cg_en", cg_en, 4'b1010);
        step(2);
        chk("allow_ready", dom_ready, 4'b1010);
        step(20);
        chk("allow_hold_cg_en", cg_en, 4'b1010);
        chk("allow_hold_gated", dom_gated, 4'b0101);
        chk("allow_all_gated", {3'b000, all_gated}, 4'b0000);
        gate_allow = 4'b1111;
        step(16);
        chk("allow_regate", cg_en, 4'b0000);
        chk("allow_regate_all", {3'b000, all_gated}, 4'b0001);
        force_on = 1'b1;
        step(1);
        chk("force_cg_en", cg_en, 4'b1111);
        chk("force_ready_k", dom_ready, 4'b0000);
        chk("force_all_gated", {3'b000, all_gated}, 4'b0000);
        step(1);
        chk("force_ready_k1", dom_ready, 4'b0000);
        step(1);
        chk("force_ready_k2", dom_ready, 4'b1111);
        step(20);
        chk("force_hold_cg_en", cg_en, 4'b1111);
        chk("force_hold_ready", dom_ready, 4'b1111);
        force_on = 1'b0;
        step(16);
        chk("force_off_regate", cg_en, 4'b0000);
        gate_allow = 4'b1110;
        step(1);
        chk("disallow0_cg_en", cg_en, 4'b0001);
        step(2);
        chk("disallow0_ready", dom_ready, 4'b0001);

        // 6: asynchronous reset while domains 1..3 are in WAKE
        gate_allow = 4'b1111;
        wake_req   = 4'b1111;
        step(1);
        chk("mid_wake_cg_en", cg_en, 4'b1111);
        chk("mid_wake_ready", dom_ready, 4'b0001);
        rst_n = 1'b0;
        #1;
        chk("async_rst_cg_en", cg_en, 4'b1111);
        chk("async_rst_ready", dom_ready, 4'b1111);
        chk("async_rst_gated", dom_gated, 4'b0000);
        wake_req = 4'b0000;
        #1;
        rst_n = 1'b1;
        step(15);
        chk("post_rst15", cg_en, 4'b1111);
        chk("post_rst15_ready", dom_ready, 4'b1111);
        step(1);
        chk("post_rst16", cg_en, 4'b0000);
        chk("post_rst16_all", {3'b000, all_gated}, 4'b0001);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
